// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE run control, absolute and PC-relative
// jumps through a small register LUT, stall hold, and a saturating run-cycle counter.
module fetch_sequencer #(
  parameter int D          = 12,
  parameter int L          = 4,
  parameter int START_ADDR = 0,
  parameter int HALT_ADDR  = 128,
  parameter int CW         = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         stall,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic [L-1:0] lut_sel,
  input  logic         lut_wr_en,
  input  logic [L-1:0] lut_wr_addr,
  input  logic [D-1:0] lut_wr_data,
  output logic [D-1:0] prog_ctr,
  output logic         instr_valid,
  output logic         busy,
  output logic         done,
  output logic [CW-1:0] cycle_count
);
  localparam logic [D-1:0] START = D'(START_ADDR);
  localparam logic [D-1:0] HALT  = D'(HALT_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   pc_nxt;
  logic           cnt_clr, cnt_inc;
  logic [D-1:0]   lut [2**L];
  logic [D-1:0]   lut_rd;

  // Read sees the pre-write contents; a same-cycle write lands at the edge.
  assign lut_rd = lut[lut_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= START;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        pc_nxt = START;
        if (req) begin
          state_nxt = RUN;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        cnt_inc = 1'b1;
        if (prog_ctr == HALT)  state_nxt = DONE;
        else if (!stall) begin
          if (absjump_en)      pc_nxt = lut_rd;
          else if (reljump_en) pc_nxt = prog_ctr + lut_rd;
          else                 pc_nxt = prog_ctr + 1'b1;
        end
      end
      DONE: begin
        if (!req) begin
          state_nxt = IDLE;
          pc_nxt    = START;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = START;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cycle_count <= '0;
    else if (cnt_clr)                   cycle_count <= '0;
    else if (cnt_inc && ~&cycle_count)  cycle_count <= cycle_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_addr] <= lut_wr_data;
    end
  end

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign instr_valid = (state == RUN) && !stall && (prog_ctr != HALT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected fetch addresses
// and end-of-run results, a negedge monitor pops and compares them.
module tb_fetch_sequencer;
  localparam int D = 12, L = 4, CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, stall, reljump_en, absjump_en, lut_wr_en;
  logic [L-1:0]  lut_sel, lut_wr_addr;
  logic [D-1:0]  lut_wr_data;
  logic [D-1:0]  prog_ctr;
  logic          instr_valid, busy, done;
  logic [CW-1:0] cycle_count;

  fetch_sequencer #(.D(D), .L(L), .START_ADDR(0), .HALT_ADDR(128), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .lut_sel(lut_sel),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .prog_ctr(prog_ctr), .instr_valid(instr_valid), .busy(busy), .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [D-1:0] pc; logic [CW-1:0] cnt; } done_t;
  logic [D-1:0] pc_q [$];
  done_t        done_q [$];
  logic         done_d = 1'b0;
  logic [D-1:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every live fetch and every end-of-run is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid) begin
        if (pc_q.size() == 0) chk("unexpected_fetch", {20'd0, prog_ctr}, 32'hFFFF_FFFF);
        else chk("fetch_pc", {20'd0, prog_ctr}, {20'd0, pc_q.pop_front()});
      end
      if (done && !done_d) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_pc", {20'd0, prog_ctr}, {20'd0, e.pc});
          chk("done_cycle_count", {16'd0, cycle_count}, {16'd0, e.cnt});
        end
      end
    end
    done_d <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [D-1:0] target);
    int guard = 0;
    while (exp_pc != target && guard < 4096) begin
      pc_q.push_back(exp_pc);
      tick();
      exp_pc = exp_pc + 1'b1;
      guard++;
    end
    // Halt cycle, then DONE on the following edge.
    tick();
    chk("run_reached_done", {31'd0, done}, 32'd1);
  endtask

  task automatic start_run();
    req = 1'b1;
    tick();
    req = 1'b0;
    exp_pc = '0;
  endtask

  task automatic lut_write(input logic [L-1:0] a, input logic [D-1:0] v);
    lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = v;
    tick();
    lut_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 0; stall = 0; reljump_en = 0; absjump_en = 0;
    lut_sel = '0; lut_wr_en = 0; lut_wr_addr = '0; lut_wr_data = '0;
    tick(); tick();
    chk("rst_pc", {20'd0, prog_ctr}, 32'd0);
    chk("rst_busy_done_iv", {29'd0, busy, done, instr_valid}, 32'd0);
    chk("rst_count", {16'd0, cycle_count}, 32'd0);
    reset = 1'b0;

    lut_write(4'd3, 12'd40);
    lut_write(4'd5, 12'hFFE);

    // Run 1: linear, req held high through the run and after done.
    req = 1'b1;
    tick();
    exp_pc = '0;
    done_q.push_back('{pc: 12'd128, cnt: 16'd129});
    run_to(12'd128);
    tick(); tick();
    chk("done_hold_req", {31'd0, done}, 32'd1);
    chk("done_hold_pc", {20'd0, prog_ctr}, 32'd128);
    chk("done_busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    tick();
    chk("idle_pc", {20'd0, prog_ctr}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_count_hold", {16'd0, cycle_count}, 32'd129);

    // Jumps outside RUN do nothing.
    absjump_en = 1'b1; lut_sel = 4'd3;
    tick();
    chk("idle_jump_ignored", {20'd0, prog_ctr}, 32'd0);
    absjump_en = 1'b0;

    // Run 2: abs jump, rel jump backwards, abs beats rel.
    start_run();
    chk("run_clears_count", {16'd0, cycle_count}, 32'd0);
    done_q.push_back('{pc: 12'd128, cnt: 16'd102});
    while (exp_pc != 12'd10) begin pc_q.push_back(exp_pc); tick(); exp_pc++; end
    absjump_en = 1'b1; lut_sel = 4'd3; pc_q.push_back(12'd10); tick();
    absjump_en = 1'b0; reljump_en = 1'b1; lut_sel = 4'd5; pc_q.push_back(12'd40); tick();
    absjump_en = 1'b1; lut_sel = 4'd3; pc_q.push_back(12'd38); tick();
    absjump_en = 1'b0; reljump_en = 1'b0;
    exp_pc = 12'd40;
    run_to(12'd128);
    tick();

    // Run 3: three stalled cycles at pc 20 with jumps asserted.
    start_run();
    done_q.push_back('{pc: 12'd128, cnt: 16'd132});
    while (exp_pc != 12'd20) begin pc_q.push_back(exp_pc); tick(); exp_pc++; end
    chk("pre_stall_count", {16'd0, cycle_count}, 32'd20);
    stall = 1'b1; absjump_en = 1'b1; reljump_en = 1'b1; lut_sel = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", {20'd0, prog_ctr}, 32'd20);
      chk("stall_iv", {31'd0, instr_valid}, 32'd0);
    end
    chk("stall_count", {16'd0, cycle_count}, 32'd23);
    stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
    run_to(12'd128);
    tick();

    // Run 4: write and jump-read of lut[2] in the same cycle.
    lut_write(4'd2, 12'd7);
    start_run();
    done_q.push_back('{pc: 12'd128, cnt: 16'd123});
    absjump_en = 1'b1; lut_sel = 4'd2;
    lut_wr_en = 1'b1; lut_wr_addr = 4'd2; lut_wr_data = 12'd99;
    pc_q.push_back(12'd0); tick();
    absjump_en = 1'b0; lut_wr_en = 1'b0;
    exp_pc = 12'd7;
    run_to(12'd128);
    tick();
    start_run();
    done_q.push_back('{pc: 12'd128, cnt: 16'd31});
    absjump_en = 1'b1; lut_sel = 4'd2;
    pc_q.push_back(12'd0); tick();
    absjump_en = 1'b0;
    exp_pc = 12'd99;
    run_to(12'd128);
    tick();

    // Run 5: reset mid-run at pc 50.
    start_run();
    while (exp_pc != 12'd50) begin pc_q.push_back(exp_pc); tick(); exp_pc++; end
    reset = 1'b1;
    #1;
    chk("midrst_pc", {20'd0, prog_ctr}, 32'd0);
    chk("midrst_busy_done_iv", {29'd0, busy, done, instr_valid}, 32'd0);
    chk("midrst_count", {16'd0, cycle_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // Run 6: lut[2] was cleared by reset, so abs jump lands on 0.
    start_run();
    done_q.push_back('{pc: 12'd128, cnt: 16'd130});
    absjump_en = 1'b1; lut_sel = 4'd2;
    pc_q.push_back(12'd0); tick();
    absjump_en = 1'b0;
    exp_pc = 12'd0;
    run_to(12'd128);
    tick();
    tick();

    chk("fetch_queue_empty", pc_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  D  12  program counter width
  L  4  jump-target LUT address width (2^L entries)
  START_ADDR  0  first instruction address
  HALT_ADDR  128  address that ends a run
  CW  16  cycle counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  req  in  1  start-run request
  stall  in  1  hold PC this cycle
  reljump_en  in  1  PC-relative jump
  absjump_en  in  1  absolute jump
  lut_sel  in  L  target LUT read index
  lut_wr_en  in  1  LUT write strobe
  lut_wr_addr  in  L  LUT write index
  lut_wr_data  in  D  LUT write value
  prog_ctr  out  D  current instruction address
  instr_valid  out  1  prog_ctr is a live, non-stalled fetch
  busy  out  1  run in progress
  done  out  1  run complete
  cycle_count  out  CW  cycles spent in RUN

Function
REQ-003 The block SHALL implement states IDLE, RUN, DONE, encoded in registers.
REQ-004 IDLE: prog_ctr = START_ADDR, busy=0, done=0, instr_valid=0; req=1 SHALL move to RUN next edge and clear cycle_count.
REQ-005 RUN: busy=1, done=0; req SHALL be ignored (no abort, no restart).
REQ-006 RUN next-PC priority, non-stalled cycle: absjump_en -> lut[lut_sel]; else reljump_en -> prog_ctr + lut[lut_sel], entry taken as D-bit two's complement, sum modulo 2^D; else prog_ctr + 1, wrapping 2^D-1 -> 0.
REQ-007 stall=1 in RUN SHALL hold prog_ctr and ignore both jump enables that cycle.
REQ-008 instr_valid SHALL equal (state==RUN) && !stall && (prog_ctr != HALT_ADDR), combinational from registered state.
REQ-009 prog_ctr==HALT_ADDR in RUN SHALL force DONE on the next edge regardless of stall or jump inputs; prog_ctr SHALL hold HALT_ADDR in DONE.
REQ-010 DONE: done=1, busy=0; SHALL remain until req=0, then IDLE next edge (prog_ctr reloads START_ADDR).
REQ-011 cycle_count SHALL increment once per RUN cycle, stalled cycles included, saturating at 2^CW-1; it SHALL hold in DONE and IDLE until next run start.
REQ-012 LUT: 2^L x D registers, combinational read by lut_sel, synchronous write on lut_wr_en in any state.
REQ-013 Same-cycle write and jump-read of one entry SHALL use the old value; new value visible next cycle.
REQ-014 Jump enables SHALL have no effect outside RUN.

Reset
REQ-015 reset=1 SHALL asynchronously force IDLE, prog_ctr=START_ADDR, cycle_count=0, all LUT entries 0, done=busy=instr_valid=0.
REQ-016 reset mid-RUN SHALL abandon the run; after release the block SHALL wait in IDLE for req.
REQ-017 All registers SHALL update only on rising clk outside reset.

Verification
REQ-018 Linear run: req pulse, no jumps/stalls, HALT_ADDR=128 -> prog_ctr 0..128, instr_valid for 128 cycles, done one cycle after prog_ctr=128, cycle_count=129.
REQ-019 Jumps: lut[3]=40, lut[5]=0xFFE; at prog_ctr=10 absjump lut_sel=3 -> 40; at 40 reljump lut_sel=5 -> 38; both enables at 38, lut_sel=3 -> 40 (abs wins).
REQ-020 Stall: stall=1 for 3 cycles at prog_ctr=20 -> prog_ctr held 20, instr_valid=0, cycle_count +3, jump inputs ignored.
REQ-021 LUT hazard: write lut[2]=99 while absjump lut_sel=2 (old value 7) -> prog_ctr=7; repeat next run -> 99.
REQ-022 Handshake/reset: hold req=1 after done -> stays DONE; drop req -> IDLE, prog_ctr=0; assert reset at prog_ctr=50 mid-run -> immediate IDLE, prog_ctr=0, LUT cleared.
